reg_file_wb: RTL

REG_FILE_WB -- requirements
Module: reg_file_wb

---
 rtl/reg_file_wb.sv | 96 +++++++++
 1 files changed

// File: rtl/reg_file_wb.sv
// Two-read, one-write register file with same-cycle write bypass and a sticky
// signed-overflow trap status that suppresses the trapped writeback.
module reg_file_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              ovf_in,
  input  logic              ovf_check,
  input  logic              ovf_clr,
  output logic              ovf_flag,
  output logic [ADDR_W-1:0] ovf_reg
);

  localparam int NREGS = 1 << ADDR_W;

  typedef enum logic {
    CLEAN   = 1'b0,
    TRAPPED = 1'b1
  } ovf_state_e;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  ovf_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ovf_reg_q, ovf_reg_d;

  logic trap;
  logic commit;
  logic fwd;

  assign trap   = wr_en & ovf_check & ovf_in;
  assign commit = wr_en & (wr_addr != '0) & ~(ovf_check & ovf_in);
  // Reset discards the in-flight write, so it must not be forwarded either.
  assign fwd    = commit & ~reset;

  // NOTE: every variable driven in always_comb gets a default first; without it a path that skips the assignment infers a latch.
  always_comb begin
    regs_d = regs_q;
    if (commit) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    ovf_reg_d = ovf_reg_q;
    if (trap) begin
      state_d = TRAPPED;
      // First-error capture; a coincident clear re-arms capture for this trap.
      if (state_q == CLEAN || ovf_clr) begin
        ovf_reg_d = wr_addr;
      end
    end else if (ovf_clr) begin
      state_d = CLEAN;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the register array is reset explicitly because reads must return 0 for every address after reset, not just r0.
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      state_q   <= CLEAN;
      ovf_reg_q <= '0;
    end else begin
      regs_q    <= regs_d;
      state_q   <= state_d;
      ovf_reg_q <= ovf_reg_d;
    end
  end

  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if (rs_addr != '0) begin
      rd_data1 = (fwd && (wr_addr == rs_addr)) ? wr_data : regs_q[rs_addr];
    end
    if (rt_addr != '0) begin
      rd_data2 = (fwd && (wr_addr == rt_addr)) ? wr_data : regs_q[rt_addr];
    end
  end

  assign ovf_flag = (state_q == TRAPPED);
  assign ovf_reg  = ovf_reg_q;

endmodule
